// File: rtl/rf_pkg.sv
// Shared types for the register-file write path: register ids, data words
// and the writeback request bundle used by both write sources.
package rf_pkg;

    localparam int REG_COUNT = 32;

    typedef logic [4:0]  reg_id_t;
    typedef logic [31:0] xlen_t;

    typedef struct packed {
        logic    valid;
        reg_id_t rd;
        xlen_t   data;
    } wb_req_t;

    // x0 is hardwired zero, so writes to it are discarded and never tracked
    function automatic logic is_x0(input reg_id_t id);
        return (id == '0);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-register scoreboard for long-latency writes: tracks which registers
// still await a result, answers decode hazard queries, counts outstanding
// registers and flags commits to registers that were never marked busy.
module regfile_scoreboard
    import rf_pkg::*;
#(
    parameter int REG_COUNT = rf_pkg::REG_COUNT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_set_valid,
    input  reg_id_t    i_set_rd,
    input  logic       i_clr_valid,
    input  reg_id_t    i_clr_rd,
    input  reg_id_t    i_query_rs1,
    input  reg_id_t    i_query_rs2,
    input  reg_id_t    i_query_rd,
    output logic       o_hazard,
    output logic [5:0] o_pending_count,
    output logic       o_sb_error
);

    logic [31:0] r_busy;
    logic        r_sb_error;
    logic [31:0] w_set_mask;
    logic [31:0] w_clr_mask;
    logic [31:0] w_busy_next;
    logic [31:0] w_busy_view;
    logic        w_commit_err;
    logic [5:0]  w_popcount;

    // Build set/clear masks; a same-cycle set on the cleared register wins
    always_comb begin
        w_set_mask   = '0;
        w_clr_mask   = '0;
        w_commit_err = 1'b0;
        if (i_set_valid && !is_x0(i_set_rd) && (32'(i_set_rd) < REG_COUNT)) begin
            w_set_mask[i_set_rd] = 1'b1;
        end
        if (i_clr_valid && !is_x0(i_clr_rd)) begin
            w_clr_mask[i_clr_rd] = 1'b1;
            w_commit_err         = !r_busy[i_clr_rd];
        end
        w_busy_next = (r_busy & ~w_clr_mask) | w_set_mask;
    end

    // Busy vector and sticky commit-error flag, both cleared by reset only
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_busy     <= '0;
            r_sb_error <= 1'b0;
        end else begin
            r_busy <= w_busy_next;
            if (w_commit_err) begin
                r_sb_error <= 1'b1;
            end
        end
    end

    assign w_busy_view = {r_busy[31:1], 1'b0};

    // Population count of the registered busy vector
    always_comb begin
        w_popcount = '0;
        for (int i = 1; i < 32; i++) begin
            w_popcount = w_popcount + 6'(w_busy_view[i]);
        end
    end

    assign o_hazard        = w_busy_view[i_query_rs1] | w_busy_view[i_query_rs2] | w_busy_view[i_query_rd];
    assign o_pending_count = w_popcount;
    assign o_sb_error      = r_sb_error;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between the single-cycle
// execute writeback (A) and a variable-latency unit (B). A normally wins;
// B is forced through once it has been refused STARVE_LIMIT cycles in a row.
module regfile_write_arbiter
    import rf_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int REG_COUNT    = rf_pkg::REG_COUNT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_a_valid,
    input  reg_id_t     i_a_rd,
    input  xlen_t       i_a_data,
    output logic        o_a_stall,
    input  logic        i_b_valid,
    input  reg_id_t     i_b_rd,
    input  xlen_t       i_b_data,
    output logic        o_b_ready,
    input  logic        i_issue_valid,
    input  reg_id_t     i_issue_rd,
    input  reg_id_t     i_query_rs1,
    input  reg_id_t     i_query_rs2,
    input  reg_id_t     i_query_rd,
    output logic        o_hazard,
    output logic        o_rf_write_en,
    output reg_id_t     o_rf_write_id,
    output xlen_t       o_rf_write_data,
    output logic [5:0]  o_pending_count,
    output logic        o_sb_error
);

    wb_req_t    w_req_a;
    wb_req_t    w_req_b;
    logic [3:0] r_starve_cnt;
    logic       w_forced;
    logic       w_a_stall;
    logic       w_b_ready;
    logic       w_write_en;
    reg_id_t    w_write_id;
    xlen_t      w_write_data;

    assign w_req_a  = '{valid: i_a_valid, rd: i_a_rd, data: i_a_data};
    assign w_req_b  = '{valid: i_b_valid, rd: i_b_rd, data: i_b_data};
    assign w_forced = (r_starve_cnt == 4'(STARVE_LIMIT));

    // Grant and write-port mux; everything idles while reset is held
    always_comb begin
        w_a_stall    = 1'b0;
        w_b_ready    = 1'b0;
        w_write_en   = 1'b0;
        w_write_id   = '0;
        w_write_data = '0;
        if (reset_n) begin
            w_b_ready = w_req_b.valid && (w_forced || !w_req_a.valid || is_x0(w_req_b.rd));
            w_a_stall = w_req_a.valid && w_req_b.valid && w_forced;
            if (w_b_ready && !is_x0(w_req_b.rd)) begin
                w_write_en   = 1'b1;
                w_write_id   = w_req_b.rd;
                w_write_data = w_req_b.data;
            end else if (w_req_a.valid && !w_a_stall && !is_x0(w_req_a.rd)) begin
                w_write_en   = 1'b1;
                w_write_id   = w_req_a.rd;
                w_write_data = w_req_a.data;
            end
        end
    end

    // Count consecutive refused B cycles, saturating at the forcing threshold
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_starve_cnt <= '0;
        end else if (w_req_b.valid && !w_b_ready) begin
            if (!w_forced) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end else begin
            r_starve_cnt <= '0;
        end
    end

    regfile_scoreboard #(
        .REG_COUNT(REG_COUNT)
    ) u_scoreboard (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_set_valid    (i_issue_valid),
        .i_set_rd       (i_issue_rd),
        .i_clr_valid    (w_b_ready),
        .i_clr_rd       (i_b_rd),
        .i_query_rs1    (i_query_rs1),
        .i_query_rs2    (i_query_rs2),
        .i_query_rd     (i_query_rd),
        .o_hazard       (o_hazard),
        .o_pending_count(o_pending_count),
        .o_sb_error     (o_sb_error)
    );

    assign o_a_stall       = w_a_stall;
    assign o_b_ready       = w_b_ready;
    assign o_rf_write_en   = w_write_en;
    assign o_rf_write_id   = w_write_id;
    assign o_rf_write_data = w_write_data;

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between the single-cycle execute writeback (port A) and a variable-latency unit such as load or mul/div (port B, valid/ready). It keeps a scoreboard of registers with outstanding long-latency writes, so the issue stage can stall on RAW/WAW hazards. It sits between the writeback stage and `register_file`, and drives that block's `write_en`/`write_id`/`write_data`.

## Interface
- `STARVE_LIMIT`, default 4: consecutive cycles B may be refused before it gets forced priority (range 1..15).
- `REG_COUNT`, default 32: number of architectural registers. Register x0 is hardwired zero.
- `clk` in 1: clock.
- `reset_n` in 1: synchronous, active-low reset.
- `a_valid` in 1: execute writeback request.
- `a_rd` in 5: execute destination register.
- `a_data` in 32: execute result.
- `a_stall` out 1: A refused this cycle. A must hold its request.
- `b_valid` in 1: long-latency result valid.
- `b_rd` in 5: long-latency destination register.
- `b_data` in 32: long-latency result.
- `b_ready` out 1: B accepted this cycle.
- `issue_valid` in 1: long-latency op issued this cycle. Marks `issue_rd` busy.
- `issue_rd` in 5: destination register of the issued op.
- `query_rs1` in 5: source register 1 of the instruction in decode.
- `query_rs2` in 5: source register 2 of the instruction in decode.
- `query_rd` in 5: destination register of the instruction in decode.
- `hazard` out 1: a decode operand or destination is busy.
- `rf_write_en` out 1: write enable to the register file.
- `rf_write_id` out 5: write address to the register file.
- `rf_write_data` out 32: write data to the register file.
- `pending_count` out 6: number of busy registers.
- `sb_error` out 1: sticky flag for a B commit to a non-busy register.

## Operation
- **Grant, combinational each cycle.**
  - Default priority: A over B.
  - B is forced when `starve_cnt == STARVE_LIMIT`. In that case, `a_stall = a_valid` and `b_ready = 1`.
  - Otherwise `b_ready = b_valid & ~a_valid`, and `a_stall = 0`.
- **Write port.**
  - `rf_write_en = 1` when the granted request has rd≠0.
  - `rf_write_id`/`rf_write_data` come from the granted port, else 0.
- **rd = 0 handling.**
  - A B request with rd = 0 is accepted immediately, even if A is valid.
  - It does not drive the write port and touches no busy bit.
  - An A request with rd = 0 is granted but not written.
- **Starvation counter `starve_cnt` (4 bits).**
  - Increments on `b_valid & ~b_ready`.
  - Clears on B acceptance or when `b_valid` is 0.
  - Saturates at `STARVE_LIMIT`.
- **Scoreboard `busy[REG_COUNT-1:1]`.**
  - `issue_valid` with `issue_rd≠0` sets `busy[issue_rd]`.
  - A B acceptance with rd≠0 clears `busy[b_rd]`.
  - If set and clear hit the same rd in the same cycle, set wins.
  - A B acceptance while `busy[b_rd] = 0` sets `sb_error`. `sb_error` clears only on reset.
- **Hazard.**
  - `hazard = busy[query_rs1] | busy[query_rs2] | busy[query_rd]`, with index 0 always reading 0.
  - Evaluated from registered `busy` only. There is no bypass of a same-cycle commit.
- **`pending_count`.** Popcount of registered `busy`, from 0 to 31.
- **Reset** (`reset_n` low at posedge):
  - `busy`, `starve_cnt` and `sb_error` clear.
  - While `reset_n` is low: `rf_write_en = 0`, `b_ready = 0`, `a_stall = 0`.
  - Any in-flight B result is dropped. The requester must re-issue after reset.

## Timing
- Grant, `a_stall`, `b_ready` and the `rf_write_*` outputs are combinational in the same cycle. The register file captures the write at the next posedge.
- A busy bit set by `issue_valid` at edge N: `hazard` is visible from cycle N+1.
- A busy bit cleared by a B commit at edge N: `hazard` drops in cycle N+1. The register file already holds the data at that point, so the decode read is correct.
- Worst-case B wait: `STARVE_LIMIT` refused cycles, then guaranteed acceptance.
- While forced, A stalls exactly one cycle per B acceptance. The counter restarts from 0 afterwards.
- Reset values: `a_stall = 0`, `b_ready = 0`, `hazard = 0`, `rf_write_en = 0`, `rf_write_id = 0`, `rf_write_data = 0`, `pending_count = 0`, `sb_error = 0`.

## Structure
- Package `rf_pkg`:
  - `REG_COUNT`.
  - `typedef logic [4:0] reg_id_t`.
  - `typedef logic [31:0] xlen_t`.
  - `typedef struct packed {logic valid; reg_id_t rd; xlen_t data;} wb_req_t`.
- Sub-module `regfile_scoreboard`:
  - Holds the busy vector, set/clear priority, hazard lookup, popcount and `sb_error`.
  - Arbitration and the starvation counter stay in the top.

## Test plan
- **A only.** `a_valid = 1`, `a_rd = 5`, `a_data = 0xDEADBEEF` → same cycle `rf_write_en = 1`, `rf_write_id = 5`, `a_stall = 0`. Next cycle, read of x5 returns 0xDEADBEEF.
- **Scoreboard round trip.**
  - `issue_valid`, `issue_rd = 7` → next cycle `hazard = 1` for `query_rs1 = 7`, and `pending_count = 1`.
  - B commit to rd 7 → `hazard = 0` and `pending_count = 0` the cycle after.
- **Starvation.** `a_valid` and `b_valid` held high, `STARVE_LIMIT = 4` → `b_ready = 0` for 4 cycles, then `b_ready = 1` and `a_stall = 1` for one cycle. The following cycle `a_stall = 0`.
- **Simultaneous set and clear.** `issue_rd = 9` and B commit to rd 9 in the same cycle → `busy[9]` stays 1. The B commit to a non-busy rd 12 → `sb_error = 1` stays high.
- **x0 handling.**
  - B with `b_rd = 0` and `a_valid = 1` → `b_ready = 1`, `a_stall = 0`, write to rd of A only.
  - `issue_rd = 0` → `pending_count` unchanged.
- **Reset mid-operation.** Three busy registers and B starving; assert `reset_n = 0` for one cycle → `pending_count = 0`, `hazard = 0`, starvation restarts from 0.
